// File: rtl/chip8_alu_pkg.sv
// Shared types for the sequential CHIP-8 ALU: operation codes, FSM states, default width.
package chip8_alu_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [3:0] {
      OP_MOV   = 4'h0,
      OP_OR    = 4'h1,
      OP_AND   = 4'h2,
      OP_XOR   = 4'h3,
      OP_ADD   = 4'h4,
      OP_SUB   = 4'h5,
      OP_SHR   = 4'h6,
      OP_SUBN  = 4'h7,
      OP_EQ    = 4'h8,
      OP_GT    = 4'h9,
      OP_RSV_A = 4'hA,
      OP_RSV_B = 4'hB,
      OP_INC   = 4'hC,
      OP_BCD   = 4'hD,
      OP_SHL   = 4'hE,
      OP_RSV_F = 4'hF
   } alu_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } alu_state_t;

endpackage

// File: rtl/chip8_bcd_dd.sv
// Iterative double-dabble binary-to-BCD converter, one add-3/shift step per clock.
module chip8_bcd_dd
   import chip8_alu_pkg::*;
#(
   parameter int WIDTH      = DEFAULT_WIDTH,
   parameter int BCD_DIGITS = 3
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [WIDTH-1:0]        a,
   output logic                    busy,
   output logic                    done,
   output logic [4*BCD_DIGITS-1:0] digits
);

   localparam int SRW = 4*BCD_DIGITS + WIDTH;
   localparam int CW  = $clog2(WIDTH+1);

   logic [SRW-1:0] sr;
   logic [SRW-1:0] sr_adj;
   logic [CW-1:0]  cnt;

   assign busy   = (cnt != '0);
   // High during the cycle whose closing edge performs the final iteration
   assign done   = busy && (cnt == CW'(1));
   assign digits = sr[SRW-1:WIDTH];

   always_comb begin
      sr_adj = sr;
      for (int i = 0; i < BCD_DIGITS; i++) begin
         if (sr[WIDTH+4*i +: 4] >= 4'd5)
            sr_adj[WIDTH+4*i +: 4] = sr[WIDTH+4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sr  <= '0;
         cnt <= '0;
      end else if (start) begin
         sr  <= {{(4*BCD_DIGITS){1'b0}}, a};
         cnt <= CW'(WIDTH);
      end else if (busy) begin
         sr  <= sr_adj << 1;
         cnt <= cnt - CW'(1);
      end
   end

endmodule

// File: rtl/chip8_alu_seq.sv
// Sequential CHIP-8 ALU with valid/ready handshake and multi-cycle BCD (FX33).
// Build option CHIP8_ALU_SHIFT_VY_EN: SHR/SHL take their operand from b instead of a.
//
// state | meaning
// IDLE  | in_ready=1, waiting for an operation
// BUSY  | double-dabble iterations running
// DONE  | out_valid=1, outputs held until out_ready
module chip8_alu_seq
   import chip8_alu_pkg::*;
#(
   parameter int WIDTH      = DEFAULT_WIDTH,
   parameter int BCD_DIGITS = 3
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [3:0]              op,
   input  logic [WIDTH-1:0]        a,
   input  logic [WIDTH-1:0]        b,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH-1:0]        result,
   output logic                    flag,
   output logic [4*BCD_DIGITS-1:0] bcd
);

   alu_state_t state, state_nxt;
   alu_op_t    op_e;

   logic                    accept;
   logic                    load_single;
   logic                    start_bcd;
   logic                    bcd_sel;
   logic [WIDTH-1:0]        alu_res;
   logic                    alu_flag;
   logic [WIDTH:0]          sum;
   logic [WIDTH-1:0]        shift_src;
   logic                    dd_busy;
   logic                    dd_done;
   logic [4*BCD_DIGITS-1:0] dd_digits;

   assign op_e      = alu_op_t'(op);
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign accept    = in_valid && in_ready;
   assign sum       = {1'b0, a} + {1'b0, b};

`ifdef CHIP8_ALU_SHIFT_VY_EN
   assign shift_src = b;
`else
   assign shift_src = a;
`endif

   always_comb begin
      alu_res  = '0;
      alu_flag = 1'b0;
      case (op_e)
         OP_MOV:  alu_res = b;
         OP_OR:   alu_res = a | b;
         OP_AND:  alu_res = a & b;
         OP_XOR:  alu_res = a ^ b;
         OP_ADD: begin
            alu_res  = sum[WIDTH-1:0];
            alu_flag = sum[WIDTH];
         end
         OP_SUB: begin
            alu_res  = a - b;
            alu_flag = (a >= b);
         end
         OP_SHR: begin
            alu_res  = {1'b0, shift_src[WIDTH-1:1]};
            alu_flag = shift_src[0];
         end
         OP_SUBN: begin
            alu_res  = b - a;
            alu_flag = (b >= a);
         end
         OP_EQ:   alu_res = {{(WIDTH-1){1'b0}}, (a == b)};
         OP_GT:   alu_res = {{(WIDTH-1){1'b0}}, (a > b)};
         OP_INC: begin
            alu_res  = a + WIDTH'(1);
            alu_flag = (a == {WIDTH{1'b1}});
         end
         OP_BCD:  alu_res = a;
         OP_SHL: begin
            alu_res  = {shift_src[WIDTH-2:0], 1'b0};
            alu_flag = shift_src[WIDTH-1];
         end
         default: begin
            alu_res  = '0;
            alu_flag = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      load_single = 1'b0;
      start_bcd   = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               if (op_e == OP_BCD) begin
                  start_bcd = 1'b1;
                  state_nxt = BUSY;
               end else begin
                  load_single = 1'b1;
                  state_nxt   = DONE;
               end
            end
         end
         BUSY: if (dd_done) state_nxt = DONE;
         DONE: if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // BCD ops register result=a, flag=0 at accept; digits come from the converter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result  <= '0;
         flag    <= 1'b0;
         bcd_sel <= 1'b0;
      end else if (load_single || start_bcd) begin
         result  <= alu_res;
         flag    <= alu_flag;
         bcd_sel <= start_bcd;
      end
   end

   assign bcd = (bcd_sel && !dd_busy) ? dd_digits : '0;

   chip8_bcd_dd #(
      .WIDTH      (WIDTH),
      .BCD_DIGITS (BCD_DIGITS)
   ) u_bcd_dd (
      .clk    (clk),
      .reset  (reset),
      .start  (start_bcd),
      .a      (a),
      .busy   (dd_busy),
      .done   (dd_done),
      .digits (dd_digits)
   );

endmodule
